// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: count stream in, checker status out.
// First-error capture ports exist only with CNT_CHECK_CAPTURE_EN.
interface count_seq_checker_if #(parameter int ERR_W = 8);
  logic [3:0] count_in;
  logic count_valid, clear_err;
  logic locked, wrap_pulse, err_pulse, range_err, err_sticky;
  logic [ERR_W-1:0] err_count;
`ifdef CNT_CHECK_CAPTURE_EN
  logic [3:0] first_exp, first_act;
  modport master(output count_in, count_valid, clear_err,
                 input locked, wrap_pulse, err_pulse, range_err, err_sticky, err_count, first_exp, first_act);
  modport slave(input count_in, count_valid, clear_err,
                output locked, wrap_pulse, err_pulse, range_err, err_sticky, err_count, first_exp, first_act);
`else
  modport master(output count_in, count_valid, clear_err,
                 input locked, wrap_pulse, err_pulse, range_err, err_sticky, err_count);
  modport slave(input count_in, count_valid, clear_err,
                output locked, wrap_pulse, err_pulse, range_err, err_sticky, err_count);
`endif
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto a 0..MAX_COUNT count stream and flags deviations.
// Optional first-error capture enabled by CNT_CHECK_CAPTURE_EN.
module count_seq_checker #(
  parameter int MAX_COUNT = 10,
  parameter int LOCK_LEN  = 3,
  parameter int ERR_W     = 8
) (
  input logic clk,
  input logic reset,
  count_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {HUNT, LOCK, TRACK} state_t;
  state_t state, state_d;
  logic [3:0] expected, exp_d, run, run_d, nxt;
  logic match, zero, at_max, wrap_d, err_d, range_d;
  logic wrap_q, err_q, range_q, sticky_q;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  assign zero    = bus.count_in == 4'd0;
  assign at_max  = bus.count_in == 4'(MAX_COUNT);
  assign match   = bus.count_in == expected;
  assign nxt     = at_max ? 4'd0 : bus.count_in + 4'd1;
  assign range_d = bus.count_valid && bus.count_in > 4'(MAX_COUNT);
  always_comb begin
    state_d = state;
    exp_d   = expected;
    run_d   = run;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.count_valid)
      case (state)
        HUNT: if (zero) begin
          state_d = LOCK_LEN == 1 ? TRACK : LOCK;
          run_d   = 4'd1;
          exp_d   = nxt;
        end
        LOCK: if (match) begin
          run_d   = run + 4'd1;
          exp_d   = nxt;
          state_d = run + 4'd1 >= 4'(LOCK_LEN) ? TRACK : LOCK;
        end else if (zero) begin
          run_d = 4'd1;
          exp_d = nxt;
        end else state_d = HUNT;
        TRACK: if (match) begin
          exp_d  = nxt;
          wrap_d = at_max;
        end else begin
          err_d   = 1'b1;
          state_d = zero ? LOCK : HUNT;
          run_d   = 4'd1;
          exp_d   = nxt;
        end
        default: state_d = HUNT;
      endcase
  end
  // a new error outranks a simultaneous clear, so the count restarts at 1
  assign cnt_d = err_d ? (bus.clear_err ? ERR_W'(1) : (&cnt_q ? cnt_q : cnt_q + ERR_W'(1)))
                       : (bus.clear_err ? '0 : cnt_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= HUNT;
      expected <= '0;
      run      <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      range_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_d;
      expected <= exp_d;
      run      <= run_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      range_q  <= range_d;
      sticky_q <= err_d | (sticky_q & ~bus.clear_err);
      cnt_q    <= cnt_d;
    end
  assign bus.locked     = state == TRACK;
  assign bus.wrap_pulse = wrap_q;
  assign bus.err_pulse  = err_q;
  assign bus.range_err  = range_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_count  = cnt_q;
`ifdef CNT_CHECK_CAPTURE_EN
  logic [3:0] fexp_q, fact_q;
  logic cap;
  assign cap = err_d && (!sticky_q || bus.clear_err);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fexp_q <= '0;
      fact_q <= '0;
    end else begin
      fexp_q <= cap ? expected : (bus.clear_err ? 4'd0 : fexp_q);
      fact_q <= cap ? bus.count_in : (bus.clear_err ? 4'd0 : fact_q);
    end
  assign bus.first_exp = fexp_q;
  assign bus.first_act = fact_q;
`endif
endmodule
